// File: rtl/gnn_pkg.sv
// Shared widths, sizes and FSM encoding for the
// two-layer GNN MAC scheduler.
package gnn_pkg;

    localparam int X_W    = 5;
    localparam int H_W    = 12;
    localparam int ACC2_W = 18;
    localparam int OUT_W  = 21;
    localparam int NODES  = 4;
    localparam int FEAT   = 4;
    localparam int HID    = 4;
    localparam int OUTS   = 2;
    localparam int P_W    = H_W + X_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_L1,
        S_L2,
        S_DONE
    } state_e;

    function automatic logic [H_W-1:0] relu(
        input logic [ACC2_W-1:0] s
    );
        return s[ACC2_W-1] ? '0 : s[H_W-1:0];
    endfunction

endpackage

// File: rtl/gnn_mac.sv
// Shared signed MAC: one 12x5 product per enabled cycle,
// accumulated into 18 bits; clr restarts on the same edge.
module gnn_mac
    import gnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic [H_W-1:0]    a,
    input  logic [X_W-1:0]    b,
    output logic [ACC2_W-1:0] sum
);

    logic signed [H_W-1:0]    a_s;
    logic signed [X_W-1:0]    b_s;
    logic signed [P_W-1:0]    prod;
    logic        [ACC2_W-1:0] acc_q;
    logic        [ACC2_W-1:0] acc_d;

    assign a_s  = a;
    assign b_s  = b;
    assign prod = a_s * b_s;
    assign sum  = acc_q + {{(ACC2_W-P_W){prod[P_W-1]}}, prod};

    always_comb begin
        acc_d = acc_q;
        if (en) begin
            acc_d = clr ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/gnn_mac_sched.sv
// Sequences layer-1 and layer-2 MACs for four nodes over one
// shared multiplier and writes two results per node.
module gnn_mac_sched
    import gnn_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    output logic [3:0]       x_addr,
    input  logic [X_W-1:0]   x_data,
    output logic [4:0]       w_addr,
    input  logic [X_W-1:0]   w_data,
    output logic             res_we,
    output logic [2:0]       res_addr,
    output logic [OUT_W-1:0] res_data,
    output logic             busy,
    output logic             done
);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         node_q, node_d;
    logic [H_W-1:0]     h_q [HID];
    logic [H_W-1:0]     h_d [HID];
    logic               res_we_q, res_we_d;
    logic [2:0]         res_addr_q, res_addr_d;
    logic [OUT_W-1:0]   res_data_q, res_data_d;

    logic               mac_en;
    logic               mac_clr;
    logic [H_W-1:0]     mac_a;
    logic [ACC2_W-1:0]  mac_sum;

    gnn_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .clr   (mac_clr),
        .a     (mac_a),
        .b     (w_data),
        .sum   (mac_sum)
    );

    // L1: cnt = j*4+i (i in low bits); L2: cnt = k*4+j
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        node_d     = node_q;
        h_d        = h_q;
        res_we_d   = 1'b0;
        res_addr_d = res_addr_q;
        res_data_d = res_data_q;
        x_addr     = '0;
        w_addr     = '0;
        mac_en     = 1'b0;
        mac_clr    = 1'b0;
        mac_a      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_L1;
                    cnt_d   = '0;
                    node_d  = '0;
                end
            end
            S_L1: begin
                x_addr = {node_q, cnt_q[1:0]};
                w_addr = {1'b0, cnt_q[1:0], cnt_q[3:2]};
                mac_a  = {{(H_W-X_W){x_data[X_W-1]}}, x_data};
                if (!stall) begin
                    mac_en = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        mac_clr            = 1'b1;
                        h_d[cnt_q[3:2]]    = relu(mac_sum);
                    end
                    if (cnt_q == 4'd15) begin
                        state_d = S_L2;
                    end
                end
            end
            S_L2: begin
                w_addr = {2'b10, cnt_q[1:0], cnt_q[2]};
                mac_a  = h_q[cnt_q[1:0]];
                if (!stall) begin
                    mac_en = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q[1:0] == 2'd3) begin
                        mac_clr    = 1'b1;
                        res_we_d   = 1'b1;
                        res_addr_d = {node_q, cnt_q[2]};
                        res_data_d = {{(OUT_W-ACC2_W){mac_sum[ACC2_W-1]}},
                                      mac_sum};
                    end
                    if (cnt_q == 4'd7) begin
                        cnt_d = '0;
                        if (node_q == 2'd3) begin
                            state_d = S_DONE;
                        end else begin
                            node_d  = node_q + 2'd1;
                            state_d = S_L1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            node_q     <= '0;
            for (int j = 0; j < HID; j++) h_q[j] <= '0;
            res_we_q   <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            node_q     <= node_d;
            for (int j = 0; j < HID; j++) h_q[j] <= h_d[j];
            res_we_q   <= res_we_d;
            res_addr_q <= res_addr_d;
            res_data_q <= res_data_d;
        end
    end

    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_gnn_mac_sched.sv
// Directed bench for gnn_mac_sched: table of whole-inference
// runs plus reset and restart corner sequences.
module tb_gnn_mac_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [3:0]  x_addr;
    logic [4:0]  x_data;
    logic [4:0]  w_addr;
    logic [4:0]  w_data;
    logic        res_we;
    logic [2:0]  res_addr;
    logic [20:0] res_data;
    logic        busy;
    logic        done;

    logic signed [4:0] xmem [16];
    logic signed [4:0] wmem [32];

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        int xv;
        int w1v;
        int w2v;
        int pattern;
        int st0;
        int stlen;
        int restart;
        int exp_res;
        int exp_done;
    } vec_t;

    vec_t tbl [6];

    gnn_mac_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stall    (stall),
        .x_addr   (x_addr),
        .x_data   (x_data),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .res_we   (res_we),
        .res_addr (res_addr),
        .res_data (res_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    assign x_data = xmem[x_addr];
    assign w_data = wmem[w_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(output int r [8]);
        int h [4];
        int s;
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int i = 0; i < 4; i++)
                    s += int'(xmem[n*4+i]) * int'(wmem[i*4+j]);
                h[j] = (s < 0) ? 0 : s;
            end
            for (int k = 0; k < 2; k++) begin
                s = 0;
                for (int j = 0; j < 4; j++)
                    s += h[j] * int'(wmem[16+j*2+k]);
                r[n*2+k] = s;
            end
        end
    endfunction

    task automatic load(input vec_t v);
        for (int a = 0; a < 16; a++)
            xmem[a] = v.pattern ? 5'((a*3) % 11 - 5) : 5'(v.xv);
        for (int a = 0; a < 32; a++) begin
            if (v.pattern)
                wmem[a] = (a < 24) ? 5'((a*5) % 13 - 6) : 5'(0);
            else if (a < 16)
                wmem[a] = 5'(v.w1v);
            else if (a < 24)
                wmem[a] = 5'(v.w2v);
            else
                wmem[a] = 5'(0);
        end
    endtask

    task automatic run_case(input vec_t v, input int id);
        int exp_r [8];
        int nres;
        int ndone;
        int dcyc;
        load(v);
        if (v.pattern) model(exp_r);
        else for (int i = 0; i < 8; i++) exp_r[i] = v.exp_res;
        nres  = 0;
        ndone = 0;
        dcyc  = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (c == 1) chk($sformatf("busy_first_%0d", id), int'(busy), 1);
            if (res_we) begin
                if (nres < 8) begin
                    chk($sformatf("res_addr_%0d_%0d", id, nres),
                        int'(res_addr), nres);
                    chk($sformatf("res_data_%0d_%0d", id, nres),
                        int'($signed(res_data)), exp_r[nres]);
                end
                nres++;
            end
            if (done) begin
                ndone++;
                dcyc = c;
                chk($sformatf("busy_at_done_%0d", id), int'(busy), 1);
            end
            stall = (c >= v.st0) && (c < v.st0 + v.stlen);
            start = (c == v.restart);
            if (dcyc > 0 && c >= dcyc + 2) break;
        end
        stall = 1'b0;
        start = 1'b0;
        chk($sformatf("n_res_%0d", id), nres, 8);
        chk($sformatf("n_done_%0d", id), ndone, 1);
        chk($sformatf("done_cycle_%0d", id), dcyc, v.exp_done);
        chk($sformatf("idle_busy_%0d", id), int'(busy), 0);
        chk($sformatf("idle_xaddr_%0d", id), int'(x_addr), 0);
        chk($sformatf("idle_waddr_%0d", id), int'(w_addr), 0);
    endtask

    initial begin
        tbl[0] = '{15, 15, 15, 0, 0, 0, 0, 54000, 97};
        tbl[1] = '{-16, -16, -16, 0, 0, 0, 0, -65536, 97};
        tbl[2] = '{1, -1, 7, 0, 0, 0, 0, 0, 97};
        tbl[3] = '{15, 15, 15, 0, 55, 5, 0, 54000, 102};
        tbl[4] = '{15, 15, 15, 0, 0, 0, 50, 54000, 97};
        tbl[5] = '{0, 0, 0, 1, 0, 0, 0, 0, 97};

        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        load(tbl[0]);
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_res_we", int'(res_we), 0);
        chk("rst_res_data", int'(res_data), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_xaddr", int'(x_addr), 0);
        chk("idle_waddr", int'(w_addr), 0);

        for (int t = 0; t < 6; t++) run_case(tbl[t], t);

        // start together with stall in IDLE is still accepted
        load(tbl[0]);
        @(negedge clk);
        start = 1'b1;
        stall = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        chk("start_with_stall_busy", int'(busy), 1);

        // abandon that run with an asynchronous reset at cycle 40
        repeat (38) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_res_we", int'(res_we), 0);
        chk("mid_rst_res_addr", int'(res_addr), 0);
        chk("mid_rst_res_data", int'(res_data), 0);
        chk("mid_rst_xaddr", int'(x_addr), 0);
        chk("mid_rst_waddr", int'(w_addr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst_we_%0d", c), int'(res_we), 0);
        end
        run_case(tbl[0], 6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gnn_mac_sched.md
GNN_MAC_SCHED -- requirements
Module: gnn_mac_sched

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, begin one inference over all 4 nodes; sampled only in IDLE.
REQ-004 SHALL have port stall, input, 1, freeze sequencing in compute states.
REQ-005 SHALL have port x_addr, output, 4, feature index node*4+feat into external feature store.
REQ-006 SHALL have port x_data, input, 5, signed feature, valid combinationally in the same cycle as x_addr.
REQ-007 SHALL have port w_addr, output, 5, weight index: 0..15 layer-1 (i*4+j), 16..23 layer-2 (16+j*2+k).
REQ-008 SHALL have port w_data, input, 5, signed weight, combinational same-cycle read.
REQ-009 SHALL have port res_we, output, 1, one-cycle result write strobe.
REQ-010 SHALL have port res_addr, output, 3, result index node*2+k.
REQ-011 SHALL have port res_data, output, 21, signed result, sign-extended.
REQ-012 SHALL have ports busy and done, outputs, 1 each: busy = inference in progress; done = one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> L1 -> L2 -> (next node L1 | DONE) -> IDLE, using one shared signed MAC (1 product per unstalled cycle).
REQ-014 L1 for node n, hidden j=0..3, term i=0..3: x_addr=n*4+i, w_addr=i*4+j; acc += x_data*w_data (5x5 -> 10-bit product).
REQ-015 On L1 term i=3: h[j] <= ReLU(acc+product) as 12-bit signed (negative -> 0); acc cleared same edge.
REQ-016 L2 for output k=0..1, term j=0..3: w_addr=16+j*2+k, operand h[j]; 12x5 product, 18-bit signed accumulator.
REQ-017 On L2 term j=3 (unstalled) at cycle t: res_we=1, res_addr=n*2+k, res_data=sext21(sum) in cycle t+1.
REQ-018 Schedule: 24 MAC cycles per node, 96 total; start sampled at edge 0 -> first MAC cycle 1 -> final res_we and done both in cycle 97 with zero stalls.
REQ-019 busy SHALL be 1 from cycle 1 through the done cycle inclusive; 0 in IDLE.
REQ-020 start while busy SHALL be ignored; start and stall together in IDLE SHALL be accepted.
REQ-021 stall=1 in L1/L2 SHALL hold counters, acc, h[], x_addr, w_addr; no new res_we issued; a res_we already scheduled from the prior cycle still fires.
REQ-022 Each stalled cycle SHALL delay done by exactly one cycle.
REQ-023 x_addr and w_addr SHALL be 0 in IDLE.

Reset
REQ-024 rst_n low SHALL, asynchronously, force IDLE, all counters, acc and h[] to 0, and every output (x_addr, w_addr, res_we, res_addr, res_data, busy, done) to 0.
REQ-025 Reset mid-inference SHALL abandon the run with no further res_we; the next start SHALL begin at node 0.

Structure
REQ-026 Shared package gnn_pkg SHALL hold X_W=5, H_W=12, ACC2_W=18, OUT_W=21, NODES=4, FEAT=4, HID=4, OUTS=2 and the FSM state enum.
REQ-027 The MAC SHALL be a sub-module gnn_mac (signed multiply, accumulate, clear, hold enable).

Verification
REQ-028 All x=+15, all w=+15, start -> 8 res_we, each res_data=54000, done at cycle 97.
REQ-029 All x=-16, all w=-16 -> h=1024 each, every res_data=-65536.
REQ-030 All x=+1, layer-1 w=-1, layer-2 w=+7 -> ReLU clamps, every res_data=0.
REQ-031 Max-value run with stall=1 for 5 cycles mid-L1 of node 2 -> results unchanged (54000), done at cycle 102.
REQ-032 rst_n low at cycle 40, then start -> outputs 0 during reset, full 8 results from node 0, no stale res_we.
REQ-033 start re-pulsed at cycle 50 of a run -> ignored; exactly 8 res_we and one done.
